// File: rtl/gene_byte_unpacker_pkg.sv
// ----------------------------------------------------------------------------
// gene_byte_unpacker_pkg
// Shared definitions for the nucleotide pack/unpack path.
//   - CODE_A/C/G/T   : 2-bit nucleotide codes (A=00, C=01, G=10, T=11)
//   - ASCII_UP_*     : upper-case ASCII characters for each base
//   - ASCII_LO_*     : lower-case ASCII characters for each base
//   - state_t        : unpacker FSM states
//   - code2ascii()   : 2-bit code -> ASCII character
//   - ascii2code()   : ASCII character -> 2-bit code (packer direction)
// ----------------------------------------------------------------------------
package gene_byte_unpacker_pkg;

    localparam logic [1:0] CODE_A = 2'b00;
    localparam logic [1:0] CODE_C = 2'b01;
    localparam logic [1:0] CODE_G = 2'b10;
    localparam logic [1:0] CODE_T = 2'b11;

    localparam logic [7:0] ASCII_UP_A = 8'h41;
    localparam logic [7:0] ASCII_UP_C = 8'h43;
    localparam logic [7:0] ASCII_UP_G = 8'h47;
    localparam logic [7:0] ASCII_UP_T = 8'h54;

    localparam logic [7:0] ASCII_LO_A = 8'h61;
    localparam logic [7:0] ASCII_LO_C = 8'h63;
    localparam logic [7:0] ASCII_LO_G = 8'h67;
    localparam logic [7:0] ASCII_LO_T = 8'h74;

    // IDLE: no byte held; EMIT: a byte is held and bases remain to send
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Map a 2-bit nucleotide code to its ASCII character
    function automatic logic [7:0] code2ascii(input logic [1:0] code, input logic lower);
        logic [7:0] ch;
        case (code)
            CODE_A:  ch = lower ? ASCII_LO_A : ASCII_UP_A;
            CODE_C:  ch = lower ? ASCII_LO_C : ASCII_UP_C;
            CODE_G:  ch = lower ? ASCII_LO_G : ASCII_UP_G;
            default: ch = lower ? ASCII_LO_T : ASCII_UP_T;
        endcase
        return ch;
    endfunction

    // Map an ASCII base (either case) back to its 2-bit code; unknown -> A
    function automatic logic [1:0] ascii2code(input logic [7:0] ch);
        logic [1:0] code;
        case (ch)
            ASCII_UP_C, ASCII_LO_C: code = CODE_C;
            ASCII_UP_G, ASCII_LO_G: code = CODE_G;
            ASCII_UP_T, ASCII_LO_T: code = CODE_T;
            default:                code = CODE_A;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/gene_byte_unpacker_code2ascii.sv
// ----------------------------------------------------------------------------
// gene_code2ascii
// Combinational 2-bit nucleotide code to 8-bit ASCII character map.
// Parameters:
//   LOWERCASE : 1 = 'a','c','g','t'; 0 = 'A','C','G','T'
// Ports:
//   i_code  [1:0] : nucleotide code
//   o_ascii [7:0] : ASCII character
// ----------------------------------------------------------------------------
module gene_code2ascii
    import gene_byte_unpacker_pkg::*;
#(
    parameter bit LOWERCASE = 1'b0
) (
    input  logic [1:0] i_code,
    output logic [7:0] o_ascii
);

    assign o_ascii = code2ascii(i_code, LOWERCASE);

endmodule

// File: rtl/gene_byte_unpacker.sv
// ----------------------------------------------------------------------------
// gene_byte_unpacker
// Accepts one packed byte holding four 2-bit nucleotide codes and emits the
// corresponding ASCII bases one per clock, with valid/ready on both sides.
// A final byte of a frame may carry fewer than four bases.
// Parameters:
//   MSB_FIRST : 1 = first base in bits [7:6]; 0 = first base in bits [1:0]
//   LOWERCASE : 1 = lower-case ASCII output; 0 = upper-case
// Ports:
//   clk          : system clock, rising edge
//   rst_n        : asynchronous active-low reset
//   i_in_valid   : packed byte available
//   o_in_ready   : byte accepted this cycle
//   i_in_data    : four 2-bit codes
//   i_in_last    : byte is the final byte of a frame
//   i_in_nbases  : valid bases in a final byte (0 means 4)
//   o_out_valid  : ASCII base valid
//   i_out_ready  : sink accepts base
//   o_out_data   : ASCII base
//   o_out_last   : final base of frame
// ----------------------------------------------------------------------------
module gene_byte_unpacker
    import gene_byte_unpacker_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1,
    parameter bit LOWERCASE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_in_valid,
    output logic       o_in_ready,
    input  logic [7:0] i_in_data,
    input  logic       i_in_last,
    input  logic [1:0] i_in_nbases,
    output logic       o_out_valid,
    input  logic       i_out_ready,
    output logic [7:0] o_out_data,
    output logic       o_out_last
);

    state_t     r_state;
    logic [7:0] r_shiftReg;
    logic [2:0] r_remaining;
    logic       r_frameEnd;
    logic [7:0] r_outData;
    logic       r_outLast;

    state_t     w_nextState;
    logic [7:0] w_nextShift;
    logic [2:0] w_nextRemaining;
    logic       w_nextFrameEnd;
    logic [1:0] w_nextCode;
    logic [7:0] w_nextAscii;
    logic       w_inXfer;
    logic       w_outXfer;

    // Accepting while the last base leaves is what keeps the stream gap-free
    assign o_in_ready  = (r_state == ST_IDLE) || ((r_remaining == 3'd1) && i_out_ready);
    assign o_out_valid = (r_state == ST_EMIT);
    assign o_out_data  = r_outData;
    assign o_out_last  = r_outLast;

    assign w_inXfer  = i_in_valid && o_in_ready;
    assign w_outXfer = o_out_valid && i_out_ready;

    // Next-state logic. A new byte always wins: in EMIT it can only arrive
    // while the final base of the held byte is transferring.
    always_comb begin
        w_nextState     = r_state;
        w_nextShift     = r_shiftReg;
        w_nextRemaining = r_remaining;
        w_nextFrameEnd  = r_frameEnd;
        if (w_inXfer) begin
            w_nextState     = ST_EMIT;
            w_nextShift     = i_in_data;
            w_nextRemaining = (i_in_last && (i_in_nbases != 2'd0)) ? {1'b0, i_in_nbases} : 3'd4;
            w_nextFrameEnd  = i_in_last;
        end else if (w_outXfer) begin
            w_nextShift     = MSB_FIRST ? (r_shiftReg << 2) : (r_shiftReg >> 2);
            w_nextRemaining = r_remaining - 3'd1;
            if (r_remaining == 3'd1) begin
                w_nextState = ST_IDLE;
            end
        end
    end

    // The current base always sits at the MSB_FIRST-selected end of the register
    assign w_nextCode = MSB_FIRST ? w_nextShift[7:6] : w_nextShift[1:0];

    gene_code2ascii #(
        .LOWERCASE(LOWERCASE)
    ) u_code2ascii (
        .i_code (w_nextCode),
        .o_ascii(w_nextAscii)
    );

    // State and output registers; outputs read as zero whenever no byte is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_shiftReg  <= 8'h00;
            r_remaining <= 3'd0;
            r_frameEnd  <= 1'b0;
            r_outData   <= 8'h00;
            r_outLast   <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_shiftReg  <= w_nextShift;
            r_remaining <= w_nextRemaining;
            r_frameEnd  <= w_nextFrameEnd;
            r_outData   <= (w_nextState == ST_EMIT) ? w_nextAscii : 8'h00;
            r_outLast   <= (w_nextState == ST_EMIT) && w_nextFrameEnd && (w_nextRemaining == 3'd1);
        end
    end

endmodule

// File: doc/gene_byte_unpacker.md
Name: gene_byte_unpacker

Overview:
- Decompression-side counterpart of the four-base packer: accepts one packed byte holding four 2-bit nucleotide codes and emits four 8-bit ASCII bases, one per clock.
- Sits on the decompression path between the packed-byte source (memory/link reader) and the ASCII sink.
- Valid/ready streaming on both sides, zero-bubble back-to-back operation, and support for a short final byte in a frame.

Parameters:
- MSB_FIRST, 1: 1 = first base in bits [7:6]; 0 = first base in bits [1:0].
- LOWERCASE, 0: 1 = emit 'a','c','g','t'; 0 = emit 'A','C','G','T'.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  packed byte available.
- in_ready  out  1  unpacker accepts byte this cycle.
- in_data  in  8  four 2-bit codes: A=00, C=01, G=10, T=11.
- in_last  in  1  byte is final byte of frame.
- in_nbases  in  2  valid bases in byte, used only when in_last=1; 0 means 4.
- out_valid  out  1  ASCII base valid.
- out_ready  in  1  sink accepts base.
- out_data  out  8  ASCII base.
- out_last  out  1  final base of frame.

Behaviour:
- Reset (async assert, sync deassert handled upstream): out_valid=0, out_data=8'h00, out_last=0, in_ready=1, shift register cleared, base counter=0, state=IDLE.
- States:
  - IDLE: no byte held.
  - EMIT: byte held, bases remaining.
- Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
- in_ready = (state==IDLE) || (remaining==1 && out_ready). This gives zero bubble: a new byte loads in the same cycle the final base of the previous byte transfers.
- On input transfer:
  - Latch in_data into the shift register.
  - Set remaining = (in_last && in_nbases!=0) ? in_nbases : 4.
  - Latch in_last into a frame-end flag.
  - Go to EMIT.
- Output is registered. Latency is 1 cycle from input transfer to first out_valid.
- In EMIT:
  - out_valid=1.
  - out_data = ASCII of the current code (first base per MSB_FIRST).
  - out_last = frame-end flag && remaining==1.
- On output transfer:
  - Shift the register by 2 bits toward the current-base position.
  - Decrement remaining.
  - If remaining was 1 and no input transfers in the same cycle, go to IDLE and set out_valid=0.
- out_valid=1 && out_ready=0: out_data and out_last stay stable; no shift.
- Short final byte (in_last=1, in_nbases=1..3): only the leading in_nbases bases are emitted; the unused trailing codes are ignored. out_last is asserted on the last emitted base.
- in_nbases is ignored when in_last=0; the byte always yields 4 bases.
- ASCII mapping:
  - 00→0x41/0x61
  - 01→0x43/0x63
  - 10→0x47/0x67
  - 11→0x54/0x74
- Simultaneous final-base output and new input in one cycle: the new byte loads, the first new base appears next cycle, and out_valid stays 1 with no gap.
- Reset mid-byte: remaining bases are discarded, no partial frame is emitted after reset, and outputs return to reset values immediately.
- Throughput: 1 base/clk sustained; one input byte accepted per 4 clk at most.

Decomposition:
- Shared gene package holds:
  - 2-bit code localparams CODE_A/C/G/T.
  - ASCII localparams for upper and lower case.
  - The code-to-ASCII function, shared with the packer's ASCII-to-code direction.
- One natural sub-module: gene_code2ascii, a combinational 2-bit → 8-bit map with a LOWERCASE parameter. Everything else lives in gene_byte_unpacker.

Test Plan:
- Defaults, out_ready=1, one byte 0x1B with in_last=0 → out_data 0x41,0x43,0x47,0x54 on 4 consecutive cycles; out_last=0 throughout; in_ready=1 during the 4th base.
- Back-to-back bytes 0x00 then 0xFF, in_valid held high → 0x41×4 then 0x54×4 with no idle cycle between; second byte accepted in the cycle of the 4th 'A'.
- 0xE4 with in_last=1, in_nbases=3 → 0x54,0x47,0x43 only; out_last=1 on 0x43; then out_valid=0.
- out_ready toggled 1,0,0,1,… on byte 0x1B → out_data holds 0x43 through the stall cycles; no base lost or duplicated; in_ready=0 while stalled.
- MSB_FIRST=0, LOWERCASE=1, byte 0x1B → 0x74,0x67,0x63,0x61.
- rst_n pulsed low after the 2nd base of 0x1B → out_valid=0 immediately, in_ready=1; next byte 0xFF yields exactly four 0x54.
